// File: rtl/ast_width_divider.sv
// ast_width_divider: Avalon-ST wide-to-narrow width converter.
// One wide word is held and shifted out MSB-first as narrow beats.
module ast_width_divider #(
  parameter int DATA_IN_W   = 64,
  parameter int DATA_OUT_W  = 16,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = $clog2(DATA_IN_W/8),
  parameter int EMPTY_OUT_W = (DATA_OUT_W > 8) ?
                              $clog2(DATA_OUT_W/8) : 1
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int K     = DATA_IN_W / DATA_OUT_W;
  localparam int BI    = DATA_IN_W / 8;
  localparam int BO    = DATA_OUT_W / 8;
  localparam int IDX_W = $clog2(K);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       last;
  logic [DATA_IN_W-1:0]   word;
  logic                   sop_q;
  logic                   eop_q;
  logic [CHANNEL_W-1:0]   chan;
  logic [EMPTY_OUT_W-1:0] pad;

  logic [31:0]            vb;
  logic [31:0]            nb;
  logic [IDX_W-1:0]       last_n;
  logic [EMPTY_OUT_W-1:0] pad_n;

  logic at_last;
  logic take;
  logic give;

  // Beat count and trailing pad of the incoming word.
  always_comb begin
    vb = 32'(BI);
    if (ast_endofpacket_i)
      vb = 32'(BI) - 32'(ast_empty_i);
    nb = (vb + 32'(BO) - 32'd1) / 32'(BO);
    last_n = IDX_W'(K - 1);
    if (ast_endofpacket_i)
      last_n = IDX_W'(nb - 32'd1);
    pad_n = EMPTY_OUT_W'(nb * 32'(BO) - vb);
  end

  assign at_last     = (idx == last);
  assign ast_valid_o = (state == SEND);
  // ready_i feeds ready_o so a new word loads on the last beat.
  assign ast_ready_o = (state == IDLE) ||
                       (at_last && ast_ready_i);

  assign take = ast_valid_i && ast_ready_o;
  assign give = ast_valid_o && ast_ready_i;

  assign ast_data_o          = word[DATA_IN_W-1 -: DATA_OUT_W];
  assign ast_startofpacket_o = ast_valid_o && sop_q &&
                               (idx == '0);
  assign ast_endofpacket_o   = ast_valid_o && eop_q && at_last;
  assign ast_empty_o         = ast_endofpacket_o ? pad : '0;
  assign ast_channel_o       = chan;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      word  <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      chan  <= '0;
      pad   <= '0;
    end else if (take) begin
      state <= SEND;
      idx   <= '0;
      last  <= last_n;
      word  <= ast_data_i;
      sop_q <= ast_startofpacket_i;
      eop_q <= ast_endofpacket_i;
      chan  <= ast_channel_i;
      pad   <= pad_n;
    end else if (give) begin
      if (at_last) begin
        state <= IDLE;
      end else begin
        idx  <= idx + IDX_W'(1);
        word <= word << DATA_OUT_W;
      end
    end
  end

endmodule

// File: doc/ast_width_divider.md
# ast_width_divider

Avalon-ST wide-to-narrow width converter: accepts packets on a DATA_IN_W-bit sink and re-emits them as DATA_OUT_W-bit beats on the source, preserving start/end of packet, channel and trailing-byte empty. It is the down-converting counterpart to the converter's narrow-to-wide path. It sits between a wide upstream producer and a narrow downstream consumer. Both ends use the team's `ast_interface` signal set.

## Interface
- DATA_IN_W, 64, sink data width in bits; multiple of 8.
- DATA_OUT_W, 16, source data width in bits; multiple of 8. K = DATA_IN_W/DATA_OUT_W is an integer power of 2, K >= 2.
- CHANNEL_W, 10, channel width.
- EMPTY_IN_W, $clog2(DATA_IN_W/8), sink empty width.
- EMPTY_OUT_W, max(1, $clog2(DATA_OUT_W/8)), source empty width.
- clk  in  1  clock; all logic on the rising edge.
- srst  in  1  asynchronous, active-high reset.
- ast_data_i  in  DATA_IN_W  sink data; first symbol in the MSBs.
- ast_startofpacket_i  in  1  sink SOP.
- ast_endofpacket_i  in  1  sink EOP.
- ast_valid_i  in  1  sink valid.
- ast_empty_i  in  EMPTY_IN_W  unused bytes in the EOP word; ignored when EOP is 0.
- ast_channel_i  in  CHANNEL_W  sink channel.
- ast_ready_o  out  1  sink ready.
- ast_data_o  out  DATA_OUT_W  source data.
- ast_startofpacket_o  out  1  source SOP.
- ast_endofpacket_o  out  1  source EOP.
- ast_valid_o  out  1  source valid.
- ast_empty_o  out  EMPTY_OUT_W  unused bytes in the EOP beat.
- ast_channel_o  out  CHANNEL_W  source channel.
- ast_ready_i  in  1  source ready.

## Operation
- Notation: BI = DATA_IN_W/8 and BO = DATA_OUT_W/8.
- One-word holding register plus beat index `idx`, with states IDLE and SEND.
- Sink transfer occurs when ast_valid_i && ast_ready_o; source transfer occurs when ast_valid_o && ast_ready_i.
- **On accept:**
  - Capture data, SOP, EOP and channel.
  - Compute valid_bytes = EOP ? BI - ast_empty_i : BI.
  - Compute last_idx = EOP ? ceil(valid_bytes/BO) - 1 : K - 1.
  - Set the trailing empty to (last_idx+1)*BO - valid_bytes.
  - Set idx = 0 and enter SEND.
- **Beat i output:**
  - ast_data_o = word[DATA_IN_W-1-i*DATA_OUT_W -: DATA_OUT_W]; implemented as a left shift of the holding register.
  - ast_startofpacket_o = captured SOP && i == 0.
  - ast_endofpacket_o = captured EOP && i == last_idx.
  - ast_empty_o = trailing empty when i == last_idx && EOP, else 0.
  - ast_channel_o is held constant for all beats of a word.
- **Advancing:**
  - On a source transfer with idx < last_idx: idx increments.
  - On a source transfer with idx == last_idx: the word is done. The block goes to IDLE, or reloads directly if a sink transfer occurs in the same cycle.
  - Beats of the EOP word beyond last_idx are never emitted.
- **Ready:** ast_ready_o = (state == IDLE) || (idx == last_idx && ast_ready_i).
  - This is a combinational path from ast_ready_i; it is intentional and gives bubble-free operation.
- **Non-goals:** no protocol checking. SOP/EOP nesting and mid-packet channel changes pass through unchanged.
- **Data outputs while idle:** ast_data_o, ast_empty_o and ast_channel_o are don't-care when ast_valid_o is 0. The SOP/EOP outputs are 0 whenever ast_valid_o is 0.

## Timing
- **Reset values** (srst high, asynchronously):
  - State is IDLE, idx = 0 and ast_valid_o = 0.
  - ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_data_o and ast_channel_o are all 0.
  - ast_ready_o = 1 (combinational from IDLE).
- **Reset mid-packet:** the held word is discarded and no EOP is emitted. The first beat after deassertion comes only from a new sink transfer.
- **Latency:** a word accepted at edge N produces its first beat with ast_valid_o = 1 in the cycle after edge N.
- **Throughput:** one narrow beat per cycle while ast_ready_i = 1 and upstream keeps valid high. No gap cycles occur at word or packet boundaries.
- **Backpressure:** while ast_valid_o && !ast_ready_i, all source outputs hold stable and ast_ready_o = 0.
- **Minimum-length word:** with K beats and an EOP word whose valid_bytes <= BO, exactly one beat is emitted, carrying both SOP and EOP if the word had SOP.

## Test plan
- **Basic packet:** defaults; 3-word packet, words 0..2 = 0x0001020304050607, 0x08..0F, 0x10..17, EOP empty=3 → 11 beats 0x0001, 0x0203 … 0x1011, 0x1213, 0x14xx; SOP on beat 0 only; EOP+empty=1 on beat 10.
- **Single short word:** 1-word packet SOP+EOP, empty=6 → one beat 0x0001, SOP=EOP=1, empty=0. Then ast_ready_o returns to 1 the next cycle.
- **Streaming:** 4 back-to-back non-EOP words then an EOP word (empty=0) with ast_ready_i tied 1 → 20 consecutive valid beats, no gaps, ast_ready_o high only on each word's last beat.
- **Backpressure:** random ast_ready_i (50%) and random ast_valid_i over 200 packets with random lengths, empty and channel. Scoreboard the reassembled bytes, SOP/EOP count and channel → exact match, and outputs stable while stalled.
- **Reset mid-packet:** assert srst asynchronously mid-cycle during beat 2 of a word → ast_valid_o drops immediately. After release, a new 1-word packet emits correctly with no leftover beats.
- **Channel hold:** consecutive packets on channels 0x3FF then 0x001 → every beat carries its packet's channel, and the switch happens exactly at the first beat of the second packet.
